// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Width of one displayed hex digit.
  localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/dec7seg.sv
// Hex nibble to seven-segment decoder, combinational.
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg_c   out 7  segments g..a, active-low (bit 0 = a)
module dec7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (nibble)
      4'h0:    seg_c = 7'b1000000;
      4'h1:    seg_c = 7'b1111001;
      4'h2:    seg_c = 7'b0100100;
      4'h3:    seg_c = 7'b0110000;
      4'h4:    seg_c = 7'b0011001;
      4'h5:    seg_c = 7'b0010010;
      4'h6:    seg_c = 7'b0000010;
      4'h7:    seg_c = 7'b1111000;
      4'h8:    seg_c = 7'b0000000;
      4'h9:    seg_c = 7'b0010000;
      4'hA:    seg_c = 7'b0001000;
      4'hB:    seg_c = 7'b0000011;
      4'hC:    seg_c = 7'b1000110;
      4'hD:    seg_c = 7'b0100001;
      4'hE:    seg_c = 7'b0000110;
      4'hF:    seg_c = 7'b0001110;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans N common-anode digits through one shared decoder. Each digit gets a
// blank slot (all anodes off, anti-ghosting) followed by a lit slot. New
// display values are committed only on entry to digit 0's blank slot so a
// frame never shows a mix of old and new digits.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   reset       in   1            synchronous, active-high
//   value       in   4*N_DIGITS   hex nibbles, digit 0 = value[3:0] (rightmost)
//   load        in   1            request to display value (strobe or held)
//   digit_en    in   N_DIGITS     per-digit enable, sampled at slot start
//   load_ack    out  1            pulse: pending value committed to display
//   SevenSeg    out  7            segments g..a, active-low
//   Anode       out  N_DIGITS     digit select, active-low
//   frame_done  out  1            pulse after the last digit's lit slot
//
// Build option: define SEG7_LZ_BLANK_EN to suppress leading zeros
// (digit 0 always shows).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W*N_DIGITS-1:0] value,
  input  logic                         load,
  input  logic [N_DIGITS-1:0]          digit_en,
  output logic                         load_ack,
  output logic [6:0]                   SevenSeg,
  output logic [N_DIGITS-1:0]          Anode,
  output logic                         frame_done
);

  localparam int unsigned VAL_W   = NIBBLE_W * N_DIGITS;
  localparam int unsigned DIG_W   = $clog2(N_DIGITS);
  localparam int unsigned CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  scan_state_t         state_q, state_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic [VAL_W-1:0]    shown_q, shown_d;
  logic [VAL_W-1:0]    pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                load_ack_d;
  logic                frame_done_d;
  logic [6:0]          seg_d;
  logic [N_DIGITS-1:0] anode_d;

  logic [NIBBLE_W-1:0] nibble_c;
  logic [6:0]          dec_seg_c;
  logic                en_cur_c;
  logic                lz_cur_c;
  logic                commit_c;
  logic [N_DIGITS-1:0] lz_dark;

  // Leading-zero mask, derived from the committed value only.
`ifdef SEG7_LZ_BLANK_EN
  assign lz_dark[0] = 1'b0;
  for (genvar i = 1; i < N_DIGITS; i++) begin : g_lz
    assign lz_dark[i] = (shown_q[VAL_W-1:NIBBLE_W*i] == '0);
  end
`else
  assign lz_dark = '0;
`endif

  // Select the current digit's nibble, enable and blanking flag.
  always_comb begin
    nibble_c = '0;
    en_cur_c = 1'b0;
    lz_cur_c = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        nibble_c = shown_q[NIBBLE_W*i +: NIBBLE_W];
        en_cur_c = digit_en[i];
        lz_cur_c = lz_dark[i];
      end
    end
  end

  dec7seg u_dec7seg (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  // First cycle of digit 0's blank slot.
  assign commit_c = (state_q == ST_BLANK) && (digit_q == '0) && (cnt_q == '0);

  // Next-state, commit and output decode.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q + CNT_W'(1);
    en_d         = en_q;
    shown_d      = shown_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    seg_d        = SEG_OFF;
    anode_d      = '1;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          en_d    = en_cur_c;
        end
      end
      ST_SHOW: begin
        if (en_q && !lz_cur_c) begin
          anode_d = ~(N_DIGITS'(1) << digit_q);
          seg_d   = dec_seg_c;
        end
        if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (digit_q == DIG_W'(N_DIGITS - 1)) begin
            digit_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            digit_d = digit_q + DIG_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A load arriving in the commit cycle is newer than pend, so it wins.
    if (commit_c) begin
      if (load) begin
        shown_d    = value;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end else if (pend_v_q) begin
        shown_d    = pend_q;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      digit_q    <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      shown_q    <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      SevenSeg   <= SEG_OFF;
      Anode      <= '1;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      shown_q    <= shown_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      load_ack   <= load_ack_d;
      frame_done <= frame_done_d;
      SevenSeg   <= seg_d;
      Anode      <= anode_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, SLOT_CYCLES=4,
// BLANK_CYCLES=1 (20-cycle frame). Honours SEG7_LZ_BLANK_EN when defined.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] OFF = 7'h7F;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic        load_ack;
  logic [6:0]  SevenSeg;
  logic [3:0]  Anode;
  logic        frame_done;

  int checks;
  int errors;
  int ack_seen;

  logic [3:0] cap_an  [20];
  logic [6:0] cap_sg  [20];
  logic       cap_ack [20];
  logic       cap_fd  [20];

  seg7_scan_ctrl #(
    .N_DIGITS     (4),
    .SLOT_CYCLES  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .load_ack   (load_ack),
    .SevenSeg   (SevenSeg),
    .Anode      (Anode),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance to the next negedge where frame_done is high (bounded).
  task automatic wait_fd(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (load_ack === 1'b1) ack_seen++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: frame_done not seen within 40 cycles", tag);
    end
  endtask

  // Record one full frame of outputs starting the cycle after a frame_done.
  task automatic capture_frame();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      cap_an[j]  = Anode;
      cap_sg[j]  = SevenSeg;
      cap_ack[j] = load_ack;
      cap_fd[j]  = frame_done;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    @(negedge clk);
    if (load_ack === 1'b1) ack_seen++;
    value = v;
    load  = 1'b1;
    @(negedge clk);
    if (load_ack === 1'b1) ack_seen++;
    load  = 1'b0;
    value = ~v;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    digit_en = 4'hF;
    repeat (3) @(negedge clk);
    checks += 4;
    if (Anode !== 4'hF) begin errors++; $display("FAIL reset_anode got %h exp f", Anode); end
    if (SevenSeg !== OFF) begin errors++; $display("FAIL reset_seg got %h exp 7f", SevenSeg); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", load_ack); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    reset = 1'b0;
  endtask

  task automatic test_frame_period();
    ack_seen = 0;
    wait_fd("first_frame");
    for (int p = 0; p < 2; p++) begin
      int n;
      bit found;
      n = 0;
      found = 1'b0;
      for (int k = 1; k <= 40 && !found; k++) begin
        @(negedge clk);
        if (load_ack === 1'b1) ack_seen++;
        if (frame_done === 1'b1) begin
          found = 1'b1;
          n = k;
        end
      end
      checks++;
      if (n != 20) begin errors++; $display("FAIL frame_period got %0d exp 20", n); end
    end
    checks++;
    if (ack_seen != 0) begin errors++; $display("FAIL idle_ack got %0d exp 0", ack_seen); end
  endtask

  // Single mid-frame load, committed at the next frame start.
  task automatic test_load_table();
    logic [15:0] vals  [3];
    logic [3:0]  masks [3];
    logic [6:0]  segs  [3][4];
    vals[0] = 16'h1234; masks[0] = 4'hF;
    segs[0] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    vals[1] = 16'h0000; masks[1] = LZ ? 4'b0001 : 4'hF;
    segs[1] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    vals[2] = 16'h0102; masks[2] = LZ ? 4'b0111 : 4'hF;
    segs[2] = '{7'b0100100, 7'b1000000, 7'b1111001, 7'b1000000};
    for (int t = 0; t < 3; t++) begin
      int acks;
      wait_fd("load_sync");
      ack_seen = 0;
      repeat (2) @(negedge clk);
      pulse_load(vals[t]);
      wait_fd("load_commit");
      checks++;
      if (ack_seen != 0) begin errors++; $display("FAIL load_early_ack v=%h got %0d exp 0", vals[t], ack_seen); end
      capture_frame();
      acks = 0;
      for (int j = 0; j < 20; j++) acks += int'(cap_ack[j]);
      checks += 3;
      if (cap_ack[0] !== 1'b1) begin errors++; $display("FAIL load_ack v=%h got %b exp 1", vals[t], cap_ack[0]); end
      if (acks != 1) begin errors++; $display("FAIL load_ack_count v=%h got %0d exp 1", vals[t], acks); end
      if (cap_fd[19] !== 1'b1) begin errors++; $display("FAIL load_fd v=%h got %b exp 1", vals[t], cap_fd[19]); end
      for (int j = 0; j < 20; j++) begin
        logic [3:0] ea;
        logic [6:0] es;
        ea = 4'hF;
        es = OFF;
        if (j >= 1 && ((j - 1) % 5) < 4 && masks[t][(j - 1) / 5]) begin
          ea = ~(4'b0001 << ((j - 1) / 5));
          es = segs[t][(j - 1) / 5];
        end
        checks += 2;
        if (cap_an[j] !== ea) begin errors++; $display("FAIL load_anode v=%h j=%0d got %h exp %h", vals[t], j, cap_an[j], ea); end
        if (cap_sg[j] !== es) begin errors++; $display("FAIL load_seg v=%h j=%0d got %h exp %h", vals[t], j, cap_sg[j], es); end
      end
    end
  endtask

  task automatic test_last_wins();
    int acks;
    wait_fd("lw_sync");
    ack_seen = 0;
    pulse_load(16'hAAAA);
    repeat (3) @(negedge clk);
    pulse_load(16'h5555);
    wait_fd("lw_commit");
    capture_frame();
    acks = ack_seen;
    for (int j = 0; j < 20; j++) acks += int'(cap_ack[j]);
    checks += 2;
    if (cap_ack[0] !== 1'b1) begin errors++; $display("FAIL lw_ack got %b exp 1", cap_ack[0]); end
    if (acks != 1) begin errors++; $display("FAIL lw_ack_count got %0d exp 1", acks); end
    for (int j = 0; j < 20; j++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = 4'hF;
      es = OFF;
      if (j >= 1 && ((j - 1) % 5) < 4) begin
        ea = ~(4'b0001 << ((j - 1) / 5));
        es = 7'b0010010;
      end
      checks += 2;
      if (cap_an[j] !== ea) begin errors++; $display("FAIL lw_anode j=%0d got %h exp %h", j, cap_an[j], ea); end
      if (cap_sg[j] !== es) begin errors++; $display("FAIL lw_seg j=%0d got %h exp %h", j, cap_sg[j], es); end
    end
  endtask

  task automatic test_digit_en();
    logic [3:0] mask;
    mask = 4'b1011;
    wait_fd("en_sync");
    digit_en = mask;
    capture_frame();
    digit_en = 4'hF;
    for (int j = 0; j < 20; j++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = 4'hF;
      es = OFF;
      if (j >= 1 && ((j - 1) % 5) < 4 && mask[(j - 1) / 5]) begin
        ea = ~(4'b0001 << ((j - 1) / 5));
        es = 7'b0010010;
      end
      checks += 2;
      if (cap_an[j] !== ea) begin errors++; $display("FAIL en_anode j=%0d got %h exp %h", j, cap_an[j], ea); end
      if (cap_sg[j] !== es) begin errors++; $display("FAIL en_seg j=%0d got %h exp %h", j, cap_sg[j], es); end
    end
  endtask

  // Load presented during the commit cycle itself bypasses pend.
  task automatic test_commit_cycle_load();
    logic [3:0] mask;
    logic [6:0] segs [4];
    int acks;
    mask = LZ ? 4'b0011 : 4'hF;
    segs = '{7'b1000000, 7'b0001110, 7'b1000000, 7'b1000000};
    wait_fd("cc_sync");
    value = 16'h00F0;
    load  = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ack !== 1'b1) begin errors++; $display("FAIL cc_ack got %b exp 1", load_ack); end
    load  = 1'b0;
    value = 16'hFFFF;
    ack_seen = 0;
    wait_fd("cc_next");
    capture_frame();
    acks = ack_seen;
    for (int j = 0; j < 20; j++) acks += int'(cap_ack[j]);
    checks++;
    if (acks != 0) begin errors++; $display("FAIL cc_second_ack got %0d exp 0", acks); end
    for (int j = 0; j < 20; j++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = 4'hF;
      es = OFF;
      if (j >= 1 && ((j - 1) % 5) < 4 && mask[(j - 1) / 5]) begin
        ea = ~(4'b0001 << ((j - 1) / 5));
        es = segs[(j - 1) / 5];
      end
      checks += 2;
      if (cap_an[j] !== ea) begin errors++; $display("FAIL cc_anode j=%0d got %h exp %h", j, cap_an[j], ea); end
      if (cap_sg[j] !== es) begin errors++; $display("FAIL cc_seg j=%0d got %h exp %h", j, cap_sg[j], es); end
    end
  endtask

  // Held load: one ack per frame, then the last capture commits on release.
  task automatic test_held_load();
    wait_fd("held_sync");
    value = 16'h1234;
    load  = 1'b1;
    ack_seen = 0;
    wait_fd("held_f1");
    wait_fd("held_f2");
    checks++;
    if (ack_seen != 2) begin errors++; $display("FAIL held_acks got %0d exp 2", ack_seen); end
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ack !== 1'b1) begin errors++; $display("FAIL held_release_ack got %b exp 1", load_ack); end
    ack_seen = 0;
    wait_fd("held_after");
    checks++;
    if (ack_seen != 0) begin errors++; $display("FAIL held_extra_ack got %0d exp 0", ack_seen); end
  endtask

  task automatic test_reset_mid_show();
    logic [3:0] mask;
    int acks;
    mask = LZ ? 4'b0001 : 4'hF;
    wait_fd("rst_sync");
    pulse_load(16'h8888);
    @(negedge clk);
    checks++;
    if (Anode !== 4'hE) begin errors++; $display("FAIL rst_pre_anode got %h exp e", Anode); end
    reset = 1'b1;
    @(negedge clk);
    checks += 4;
    if (Anode !== 4'hF) begin errors++; $display("FAIL rst_anode got %h exp f", Anode); end
    if (SevenSeg !== OFF) begin errors++; $display("FAIL rst_seg got %h exp 7f", SevenSeg); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", load_ack); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b exp 0", frame_done); end
    reset = 1'b0;
    ack_seen = 0;
    wait_fd("rst_frame");
    capture_frame();
    acks = ack_seen;
    for (int j = 0; j < 20; j++) acks += int'(cap_ack[j]);
    checks++;
    if (acks != 0) begin errors++; $display("FAIL rst_pend_ack got %0d exp 0", acks); end
    for (int j = 0; j < 20; j++) begin
      logic [3:0] ea;
      logic [6:0] es;
      ea = 4'hF;
      es = OFF;
      if (j >= 1 && ((j - 1) % 5) < 4 && mask[(j - 1) / 5]) begin
        ea = ~(4'b0001 << ((j - 1) / 5));
        es = 7'b1000000;
      end
      checks += 2;
      if (cap_an[j] !== ea) begin errors++; $display("FAIL rst_anode_frame j=%0d got %h exp %h", j, cap_an[j], ea); end
      if (cap_sg[j] !== es) begin errors++; $display("FAIL rst_seg_frame j=%0d got %h exp %h", j, cap_sg[j], es); end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ack_seen = 0;
    test_reset();
    test_frame_period();
    test_load_table();
    test_last_wins();
    test_digit_en();
    test_commit_cycle_load();
    test_held_load();
    test_reset_mid_show();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
